multi_pager: RTL and testbench
==============================

# multi_pager

Parametrised multi-channel pager: each of `CHANNELS` independent input lines is watched for `RUN_LEN` consecutive sampled zeros, and a per-channel alarm is raised once that run completes. Each alarm is either latched until acknowledged or self-clearing, selected by `STICKY`. Shared status (any-alarm flag, lowest active channel, saturating alarm-event counter) feeds the system status/interrupt logic. This block is the next-generation replacement for the single-channel, fixed three-zero pager.

## Interface

Parameters:
- `CHANNELS`, 4, number of independent input channels (≥1).
- `RUN_LEN`, 3, consecutive zeros required to raise an alarm (≥1).
- `STICKY`, 1, 1 = alarm held until `ack`; 0 = alarm also clears on a sampled `x`=1.
- `EVT_W`, 8, width of `alarm_cnt`.

Ports (clock and reset first):
- `clk`  input  1  single system clock, all state on rising edge.
- `rst`  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to `clk` externally).
- `x`  input  CHANNELS  per-channel pager line, sampled each rising edge.
- `ack`  input  CHANNELS  per-channel alarm acknowledge, sampled each rising edge.
- `z`  output  CHANNELS  per-channel alarm, registered.
- `any_z`  output  1  OR of `z`.
- `first_ch`  output  max(1,clog2(CHANNELS))  index of lowest-numbered channel with `z`=1; 0 when `any_z`=0.
- `alarm_cnt`  output  EVT_W  saturating count of IDLE→ALARM transitions, all channels.

## Operation

- Per channel: 2-state FSM {IDLE, ALARM} plus run counter `cnt`, width clog2(RUN_LEN+1).
- IDLE:
  - `x`=1 → `cnt`←0.
  - `x`=0 and `cnt`<RUN_LEN-1 → `cnt`←`cnt`+1.
  - `x`=0 and `cnt`=RUN_LEN-1 → ALARM, `cnt`←0.
  - `ack` ignored.
- ALARM:
  - `ack`=1 → IDLE, `cnt`←0, regardless of `x`. Zeros sampled in the same cycle do not count.
  - Else if STICKY=0 and `x`=1 → IDLE, `cnt`←0.
  - Else stay in ALARM.
  - `cnt` is held at 0 while in ALARM.
- `z[i]` = 1 iff channel i is in ALARM.
- `any_z` and `first_ch` are combinational decodes of the registered `z`; `first_ch` uses a fixed priority encoder where the lowest index wins.
- `alarm_cnt` adds the number of channels entering ALARM in the cycle (popcount, 0..CHANNELS). It saturates at 2^EVT_W-1 and never wraps. `ack` does not change it.
- Channels are fully independent; `ack[i]` affects only channel i.

## Timing

- Reset (`rst`=0, asynchronous): all FSMs IDLE, all `cnt`=0, `z`=0, `any_z`=0, `first_ch`=0, `alarm_cnt`=0. No output glitches above 0 during reset.
- Reset mid-run or mid-alarm aborts immediately. The zero run restarts from 0 after release.
- Alarm latency: if the RUN_LEN-th consecutive zero is sampled at edge N, `z` rises after edge N (visible during cycle N+1). `alarm_cnt` updates at the same edge.
- RUN_LEN=1: a single sampled zero in IDLE raises `z` after that edge.
- Clear latency: `ack` (or `x`=1 when STICKY=0) sampled at edge M → `z` falls after edge M.
- Re-arm after clear: a fresh RUN_LEN zeros is needed, counting from edge M+1.
- A `x`=1 sample breaks the run at any count. Runs do not persist across a break or an alarm.
- Simultaneous triggers on several channels in one cycle: all `z` rise together; `alarm_cnt` increases by their count, clamped at saturation.
- Outputs are defined every cycle. There is no handshake beyond level `ack`.

## Test plan

Settings: CHANNELS=4, RUN_LEN=3, EVT_W=8 unless noted.

- Reset then idle: hold `rst`=0 for 2 cycles, then `x`=4'hF for 10 cycles → `z`=0, `any_z`=0, `first_ch`=0, `alarm_cnt`=0 throughout.
- Basic trigger, STICKY=1: `x[2]`=0 for 3 edges → `z`=4'b0100 after the 3rd edge, `first_ch`=2, `alarm_cnt`=1. Then `x[2]`=1 → `z` stays 4'b0100. Pulse `ack[2]` one cycle → `z`=0 after that edge.
- Broken run: `x[0]` sequence 0,0,1,0,0 → `z[0]` never rises. A further 0 → `z[0]`=1, `alarm_cnt`=1.
- STICKY=0: `x[1]`=0 for 3 edges → `z[1]`=1. Next `x[1]`=1 → `z[1]`=0 after one edge with no `ack`. Then `x[1]`=0 for 2 edges → `z[1]` stays 0.
- Simultaneous, priority and ack-vs-zero: `x`=4'b0000 for 3 edges → `z`=4'hF, `first_ch`=0, `alarm_cnt`=4. `ack`=4'b0001 with `x[0]`=0 → `z`=4'hE, `first_ch`=1. `z[0]` rises again only 3 zero-samples later.
- Saturation and async reset: EVT_W=2, 5 separate alarm/ack cycles on channel 0 → `alarm_cnt` sticks at 3. Drop `rst` mid-alarm, between clock edges → `z` and `alarm_cnt` go to 0 immediately.

Source files
------------

// File: rtl/multi_pager_if.sv
// Pager bus: per-channel lines and acknowledges in, alarms and shared status out.
interface multi_pager_if #(
    parameter int CHANNELS = 4,
    parameter int EVT_W    = 8
);
    localparam int FCH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] x;
    logic [CHANNELS-1:0] ack;
    logic [CHANNELS-1:0] z;
    logic                any_z;
    logic [FCH_W-1:0]    first_ch;
    logic [EVT_W-1:0]    alarm_cnt;

    modport master (output x, ack, input z, any_z, first_ch, alarm_cnt);
    modport slave  (input x, ack, output z, any_z, first_ch, alarm_cnt);
endinterface

// File: rtl/multi_pager.sv
// Multi-channel pager: per-channel zero-run detector with latched or
// self-clearing alarms, plus shared any/first/event-count status.
module multi_pager #(
    parameter int CHANNELS = 4,
    parameter int RUN_LEN  = 3,
    parameter bit STICKY   = 1'b1,
    parameter int EVT_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    multi_pager_if.slave bus
);
    localparam int CNT_W = $clog2(RUN_LEN + 1);
    localparam int FCH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SUM_W = EVT_W + $clog2(CHANNELS + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(RUN_LEN - 1);
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-EVT_W){1'b0}}, {EVT_W{1'b1}}};

    typedef enum logic {IDLE = 1'b0, ALARM = 1'b1} state_e;

    logic [CHANNELS-1:0] z_q;
    logic [CHANNELS-1:0] enter;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_e           state;
        logic [CNT_W-1:0] cnt;

        // The run completes on this edge when the last missing zero arrives.
        assign enter[g] = (state == IDLE) && !bus.x[g] && (cnt == LAST);
        assign z_q[g]   = (state == ALARM);

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.x[g]) begin
                            cnt <= '0;
                        end else if (enter[g]) begin
                            state <= ALARM;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ALARM: begin
                        cnt <= '0;
                        if (bus.ack[g] || (!STICKY && bus.x[g])) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Number of channels raising an alarm on this edge.
    logic [SUM_W-1:0] n_enter;
    logic [SUM_W-1:0] cnt_sum;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        n_enter = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            n_enter = n_enter + SUM_W'(enter[i]);
        end
        cnt_sum = {{(SUM_W-EVT_W){1'b0}}, bus.alarm_cnt} + n_enter;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.alarm_cnt <= '0;
        end else if (cnt_sum > CNT_MAX) begin
            bus.alarm_cnt <= {EVT_W{1'b1}};
        end else begin
            bus.alarm_cnt <= cnt_sum[EVT_W-1:0];
        end
    end

    // Lowest index wins: scan downward so the last match is the lowest one.
    logic [FCH_W-1:0] first_idx;

    always_comb begin
        first_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (z_q[i]) begin
                first_idx = FCH_W'(i);
            end
        end
    end

    assign bus.z        = z_q;
    assign bus.any_z    = |z_q;
    assign bus.first_ch = first_idx;

endmodule

// File: tb/tb_multi_pager.sv
// Self-checking bench: three pager variants share one stimulus stream and are
// compared every cycle against a zero-run behavioural model.
module tb_multi_pager;
    localparam int NCH  = 4;
    localparam int RUN  = 3;
    localparam int NINS = 3;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] xv;
    logic [NCH-1:0] av;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0: sticky, 8-bit count. 1: self-clearing. 2: sticky, 2-bit count.
    multi_pager_if #(.CHANNELS(NCH), .EVT_W(8)) ia ();
    multi_pager_if #(.CHANNELS(NCH), .EVT_W(8)) ib ();
    multi_pager_if #(.CHANNELS(NCH), .EVT_W(2)) ic ();

    assign ia.x = xv;  assign ia.ack = av;
    assign ib.x = xv;  assign ib.ack = av;
    assign ic.x = xv;  assign ic.ack = av;

    multi_pager #(.CHANNELS(NCH), .RUN_LEN(RUN), .STICKY(1'b1), .EVT_W(8))
        u_a (.clk(clk), .rst(rst), .bus(ia));
    multi_pager #(.CHANNELS(NCH), .RUN_LEN(RUN), .STICKY(1'b0), .EVT_W(8))
        u_b (.clk(clk), .rst(rst), .bus(ib));
    multi_pager #(.CHANNELS(NCH), .RUN_LEN(RUN), .STICKY(1'b1), .EVT_W(2))
        u_c (.clk(clk), .rst(rst), .bus(ic));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per channel, the length of the current zero run and whether an
    // alarm is standing; per instance, the clamped number of alarms raised.
    bit m_sticky [NINS] = '{1'b1, 1'b0, 1'b1};
    int m_max    [NINS] = '{255, 255, 3};
    int m_run    [NINS][NCH];
    bit m_alm    [NINS][NCH];
    int m_evt    [NINS];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NINS; k++) begin
                m_evt[k] = 0;
                for (int c = 0; c < NCH; c++) begin
                    m_run[k][c] = 0;
                    m_alm[k][c] = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < NINS; k++) begin
                int raised;
                raised = 0;
                for (int c = 0; c < NCH; c++) begin
                    if (m_alm[k][c]) begin
                        // While alarmed, zeros are not accumulated toward a new run.
                        if (av[c] || (!m_sticky[k] && xv[c])) m_alm[k][c] = 1'b0;
                        m_run[k][c] = 0;
                    end else if (xv[c]) begin
                        m_run[k][c] = 0;
                    end else begin
                        m_run[k][c] = m_run[k][c] + 1;
                        if (m_run[k][c] == RUN) begin
                            m_alm[k][c] = 1'b1;
                            m_run[k][c] = 0;
                            raised++;
                        end
                    end
                end
                m_evt[k] = (m_evt[k] + raised > m_max[k]) ? m_max[k] : m_evt[k] + raised;
            end
        end
    end

    task automatic cmp(input int k, input logic [3:0] z, input logic any,
                       input logic [1:0] fc, input logic [7:0] cnt);
        logic [3:0] ez;
        logic [1:0] efc;
        ez  = '0;
        efc = '0;
        for (int c = 0; c < NCH; c++) ez[c] = m_alm[k][c];
        for (int c = 0; c < NCH; c++) begin
            if (m_alm[k][c]) begin
                efc = 2'(c);
                break;
            end
        end
        check($sformatf("dut%0d.z", k), 32'(z), 32'(ez));
        check($sformatf("dut%0d.any_z", k), 32'(any), 32'(ez != 0));
        check($sformatf("dut%0d.first_ch", k), 32'(fc), 32'(efc));
        check($sformatf("dut%0d.alarm_cnt", k), 32'(cnt), 32'(m_evt[k]));
    endtask

    always @(negedge clk) begin
        cmp(0, ia.z, ia.any_z, ia.first_ch, ia.alarm_cnt);
        cmp(1, ib.z, ib.any_z, ib.first_ch, ib.alarm_cnt);
        cmp(2, ic.z, ic.any_z, ic.first_ch, {6'b0, ic.alarm_cnt});
    end

    // Apply one input pair for exactly one rising edge; returns at the next negedge.
    task automatic cyc(input logic [3:0] x_in, input logic [3:0] a_in);
        xv = x_in;
        av = a_in;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        xv  = '1;
        av  = '0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.z", 32'(ia.z), 32'h0);
        check("rst.alarm_cnt", 32'(ia.alarm_cnt), 32'h0);
        rst = 1'b1;

        repeat (10) cyc(4'hF, 4'h0);
        check("idle.z", 32'(ia.z), 32'h0);
        check("idle.first_ch", 32'(ia.first_ch), 32'h0);
        check("idle.alarm_cnt", 32'(ia.alarm_cnt), 32'h0);

        // Basic trigger on channel 2.
        cyc(4'b1011, 4'h0);
        cyc(4'b1011, 4'h0);
        check("trig.pre_z", 32'(ia.z), 32'h0);
        cyc(4'b1011, 4'h0);
        check("trig.z", 32'(ia.z), 32'b0100);
        check("trig.first_ch", 32'(ia.first_ch), 32'd2);
        check("trig.alarm_cnt", 32'(ia.alarm_cnt), 32'd1);
        cyc(4'hF, 4'h0);
        check("sticky.hold", 32'(ia.z), 32'b0100);
        check("nonsticky.clear", 32'(ib.z), 32'h0);
        cyc(4'hF, 4'b0100);
        check("ack.clear", 32'(ia.z), 32'h0);
        cyc(4'hF, 4'h0);

        // Broken run on channel 0.
        cyc(4'b1110, 4'h0);
        cyc(4'b1110, 4'h0);
        cyc(4'hF,    4'h0);
        cyc(4'b1110, 4'h0);
        cyc(4'b1110, 4'h0);
        check("broken.z0", 32'(ia.z[0]), 32'h0);
        cyc(4'b1110, 4'h0);
        check("broken.z0_rise", 32'(ia.z[0]), 32'h1);
        check("broken.alarm_cnt", 32'(ia.alarm_cnt), 32'd2);
        cyc(4'hF, 4'hF);

        // Self-clearing behaviour on channel 1.
        repeat (3) cyc(4'b1101, 4'h0);
        check("ns.rise", 32'(ib.z[1]), 32'h1);
        cyc(4'hF, 4'h0);
        check("ns.fall", 32'(ib.z[1]), 32'h0);
        check("ns.sticky_peer", 32'(ia.z[1]), 32'h1);
        repeat (2) cyc(4'b1101, 4'h0);
        check("ns.rearm", 32'(ib.z[1]), 32'h0);
        cyc(4'hF, 4'hF);

        // Simultaneous triggers, priority, ack beating a same-cycle zero.
        repeat (3) cyc(4'h0, 4'h0);
        check("sim.z", 32'(ia.z), 32'hF);
        check("sim.first_ch", 32'(ia.first_ch), 32'd0);
        check("sim.alarm_cnt", 32'(ia.alarm_cnt), 32'd7);
        check("sim.sat", 32'(ic.alarm_cnt), 32'd3);
        cyc(4'h0, 4'b0001);
        check("ackz.z", 32'(ia.z), 32'hE);
        check("ackz.first_ch", 32'(ia.first_ch), 32'd1);
        repeat (2) cyc(4'h0, 4'h0);
        check("ackz.wait", 32'(ia.z[0]), 32'h0);
        cyc(4'h0, 4'h0);
        check("ackz.rise", 32'(ia.z[0]), 32'h1);
        check("ackz.alarm_cnt", 32'(ia.alarm_cnt), 32'd8);
        cyc(4'hF, 4'hF);

        // Saturation: five alarm/ack rounds on channel 0.
        for (int r = 0; r < 5; r++) begin
            repeat (3) cyc(4'b1110, 4'h0);
            cyc(4'hF, 4'h1);
        end
        check("sat.c", 32'(ic.alarm_cnt), 32'd3);
        check("sat.a", 32'(ia.alarm_cnt), 32'd13);

        // Asynchronous reset mid-alarm, between edges.
        repeat (3) cyc(4'b1110, 4'h0);
        check("arst.pre", 32'(ia.z), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("arst.z", 32'(ia.z), 32'h0);
        check("arst.any_z", 32'(ia.any_z), 32'h0);
        check("arst.alarm_cnt", 32'(ia.alarm_cnt), 32'h0);
        check("arst.c_cnt", 32'(ic.alarm_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) cyc(4'b1110, 4'h0);
        check("arst.restart", 32'(ia.z[0]), 32'h0);
        cyc(4'b1110, 4'h0);
        check("arst.rerise", 32'(ia.z[0]), 32'h1);

        // Randomised phase: zero-heavy lines, sparse acks, rare resets.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] xr;
            logic [3:0] ar;
            for (int c = 0; c < NCH; c++) begin
                xr[c] = ($urandom_range(0, 9) < 3);
                ar[c] = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            cyc(xr, ar);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
